// File: rtl/pe_psum_collector.sv
// Collects PE result rows into a small row FIFO and serialises them lane by lane.
// Latency: a row accepted in cycle N appears as lane 0 in cycle N+1. pe_ready drops when the FIFO is full or the pass quota is met.
// Optional COLLECTOR_RELU_EN: negative lane values are zeroed on push.
module pe_psum_collector #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  row_total,
    input  logic        pe_valid,
    input  logic [15:0] out1,
    input  logic [15:0] out2,
    input  logic [15:0] out3,
    input  logic [15:0] out4,
    output logic        pe_ready,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [15:0] s_data,
    output logic [1:0]  s_lane,
    output logic        s_last,
    output logic        busy,
    output logic        done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q;
    logic [7:0]             total_q;
    logic [7:0]             rows_in_q;
    logic [7:0]             rows_out_q;
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [AW:0]            count_q;
    logic [1:0]             lane_q;
    logic [DEPTH-1:0][63:0] mem_q;

    logic [63:0] row_d;
    logic [63:0] head;
    logic        push;
    logic        take;
    logic        pop;
    logic        last_row;

`ifdef COLLECTOR_RELU_EN
    function automatic logic [15:0] relu(input logic [15:0] v);
        return v[15] ? 16'h0000 : v;
    endfunction
    assign row_d = {relu(out4), relu(out3), relu(out2), relu(out1)};
`else
    assign row_d = {out4, out3, out2, out1};
`endif

    assign pe_ready = (state_q == RUN) && (count_q != FULL_CNT) && (rows_in_q < total_q);
    assign push     = pe_valid && pe_ready;
    assign s_valid  = (count_q != '0);
    assign take     = s_valid && s_ready;
    assign pop      = take && (lane_q == 2'd3);
    // 9-bit compare so row_total = 255 cannot wrap
    assign last_row = ({1'b0, rows_out_q} + 9'd1) == {1'b0, total_q};

    assign head   = mem_q[rd_ptr_q];
    assign s_data = s_valid ? head[{lane_q, 4'b0000} +: 16] : 16'h0000;
    assign s_lane = lane_q;
    assign s_last = s_valid && (lane_q == 2'd3) && last_row;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);

    // Row storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= row_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            total_q    <= 8'd0;
            rows_in_q  <= 8'd0;
            rows_out_q <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lane_q     <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        total_q    <= row_total;
                        rows_in_q  <= 8'd0;
                        rows_out_q <= 8'd0;
                        lane_q     <= 2'd0;
                        state_q    <= (row_total == 8'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (pop && last_row) begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (push) begin
                wr_ptr_q  <= wr_ptr_q + 1'b1;
                rows_in_q <= rows_in_q + 8'd1;
            end
            if (take) begin
                lane_q <= lane_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                rows_out_q <= rows_out_q + 8'd1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end
endmodule
